// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - streams a range of register-file entries out as valid/ready beats
module regfile_dump #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // End test is ptr==last_q before the increment, so last=all-ones never wraps to 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (first <= last) ? READ : FIN;
                end
            end
            READ: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    state_nxt = (ptr == last_q) ? FIN : READ;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr    <= first;
                        last_q <= last;
                    end
                end
                READ: begin
                    if (!abort) begin
                        out_data  <= rf_rd;
                        out_addr  <= ptr;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ptr != last_q) begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == FIN);
        rf_ra = (state == READ) ? ptr : '0;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_rd;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [32];
    logic [AW+DW-1:0] sb [$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_acc = -1;
    bit gap_en = 0;
    int d0;

    regfile_dump #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first(first), .last(last), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    assign rf_rd = rf[rf_ra];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // x0 is hardwired to zero, so writes to index 0 are dropped
    task automatic rf_write(input int idx, input logic [DW-1:0] val);
        if (idx != 0) rf[idx] = val;
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) sb.push_back({AW'(i), rf[i]});
    endtask

    task automatic do_start(input int f, input int l);
        first = AW'(f);
        last  = AW'(l);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_beat(input int addr, input int budget);
        int n = 0;
        while (!(out_valid && out_addr == AW'(addr)) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("beat_timeout", n < budget, 1);
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst && out_valid && out_ready && !abort) begin
            if (sb.size() == 0) begin
                check("beat_expected", sb.size(), 1);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb.pop_front();
                check("beat_addr", out_addr, e[AW+DW-1:DW]);
                check("beat_data", out_data, e[DW-1:0]);
            end
            if (gap_en && last_acc >= 0) check("beat_gap", cyc - last_acc, 2);
            last_acc = cyc;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : (32'h0A000000 | (i * 32'h00010101));
        rf_write(1, 32'h11112222);
        rf_write(2, 32'h33334444);
        rf_write(3, 32'hFFFFFFFF);
        rst = 0; start = 0; abort = 0; first = 0; last = 0; out_ready = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ra", rf_ra, 0);
        check("rst_addr_data", {out_addr, out_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        // Basic 1..3 dump, with a stray start and new range while busy
        d0 = done_cnt;
        push_range(1, 3);
        gap_en = 1; last_acc = -1;
        do_start(1, 3);
        check("lat_read", out_valid, 0);
        check("ra_read", rf_ra, 1);
        first = 9; last = 9; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("lat_send", out_valid, 1);
        check("lat_addr", out_addr, 1);
        check("ra_send", rf_ra, 0);
        wait_idle(40);
        gap_en = 0;
        check("t1_sb_empty", sb.size(), 0);
        check("t1_done", done_cnt - d0, 1);

        // Index 0 after a dropped write
        rf_write(0, 32'hDEADBEEF);
        d0 = done_cnt;
        push_range(0, 0);
        do_start(0, 0);
        wait_idle(20);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_done", done_cnt - d0, 1);

        // Top of range under backpressure, no wrap
        d0 = done_cnt;
        out_ready = 0;
        push_range(30, 31);
        do_start(30, 31);
        wait_beat(30, 10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_beat", {out_addr, out_data}, {AW'(30), rf[30]});
        end
        @(posedge clk); #1;
        out_ready = 1;
        wait_idle(40);
        repeat (4) @(posedge clk);
        #1;
        check("t3_sb_empty", sb.size(), 0);
        check("t3_done", done_cnt - d0, 1);

        // Empty range goes straight to FIN
        d0 = done_cnt;
        do_start(5, 2);
        check("t4_done_hi", done, 1);
        check("t4_busy_hi", busy, 1);
        check("t4_no_valid", out_valid, 0);
        @(posedge clk); #1;
        check("t4_done_lo", done, 0);
        check("t4_busy_lo", busy, 0);
        check("t4_done_cnt", done_cnt - d0, 1);

        // Abort in SEND of beat 4, then immediate restart
        d0 = done_cnt;
        push_range(1, 3);
        do_start(1, 31);
        wait_beat(4, 20);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done_cnt - d0, 0);
        check("t5_sb_empty", sb.size(), 0);
        push_range(7, 7);
        do_start(7, 7);
        check("t5_restart", busy, 1);
        wait_idle(20);
        check("t5_sb_after", sb.size(), 0);
        check("t5_done2", done_cnt - d0, 1);

        // Reset during beat 2
        d0 = done_cnt;
        push_range(1, 1);
        do_start(1, 3);
        wait_beat(2, 20);
        rst = 0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_out", {out_addr, out_data}, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_ra", rf_ra, 0);
        @(posedge clk); #1;
        rst = 1;
        check("t6_done_cnt", done_cnt - d0, 0);
        check("t6_sb_empty", sb.size(), 0);
        push_range(3, 3);
        do_start(3, 3);
        check("t6_restart", busy, 1);
        wait_idle(20);
        check("t6_sb_after", sb.size(), 0);
        check("t6_done2", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
